// File: rtl/ep4_cmd_parser_if.sv
// Byte-stream input and controller-facing EP4 command port of the command parser.
// The parser takes the slave side; the FIFO drain and controller glue take the master side.
interface ep4_cmd_parser_if;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  cmd_id;
   logic [15:0] cmd_length;
   logic        cmd_ready;
   logic        cmd_read;
   logic [7:0]  cmd_data;
   logic        cmd_ack;

   modport master (
      output in_data, in_valid, cmd_read, cmd_ack,
      input  in_ready, cmd_id, cmd_length, cmd_ready, cmd_data
   );

   modport slave (
      input  in_data, in_valid, cmd_read, cmd_ack,
      output in_ready, cmd_id, cmd_length, cmd_ready, cmd_data
   );
endinterface

// File: rtl/ep4_cmd_parser.sv
// EP4 command deframer: parses an ID + 16-bit length header and buffers the payload,
// then holds the finished command for the controller until it is acknowledged.
module ep4_cmd_parser #(
   parameter int MAX_COMMAND_LENGTH = 8,
   parameter int PTR_W              = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   ep4_cmd_parser_if.slave       bus,
   output logic                  overflow,
   output logic [7:0]            cmd_count
);

   typedef enum logic [2:0] {
      HDR_ID,
      HDR_LEN_HI,
      HDR_LEN_LO,
      PAYLOAD,
      HOLD
   } state_t;

   localparam logic [15:0] MAX_LEN = 16'(MAX_COMMAND_LENGTH);

   state_t         state;
   state_t         next_state;
   logic           accept;
   logic           last_byte;
   logic [15:0]    len_raw;
   logic [15:0]    len_full;
   logic [15:0]    byte_cnt;
   logic [15:0]    rd_ext;
   logic [15:0]    cmd_length;
   logic [7:0]     cmd_id;
   logic [PTR_W-1:0] rd_ptr;
   logic [7:0]     payload_buf [2**PTR_W];

   assign len_full       = {len_raw[15:8], bus.in_data};
   assign last_byte      = (byte_cnt == len_raw - 16'd1);
   assign rd_ext         = 16'(rd_ptr);
   assign bus.cmd_id     = cmd_id;
   assign bus.cmd_length = cmd_length;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= HDR_ID;
      else        state <= next_state;
   end

   always_comb begin
      next_state    = state;
      accept        = bus.in_valid && (state != HOLD);
      bus.in_ready  = (state != HOLD);
      bus.cmd_ready = (state == HOLD);
      case (state)
         HDR_ID:     if (accept) next_state = HDR_LEN_HI;
         HDR_LEN_HI: if (accept) next_state = HDR_LEN_LO;
         HDR_LEN_LO: if (accept) next_state = (len_full == 16'd0) ? HOLD : PAYLOAD;
         PAYLOAD:    if (accept && last_byte) next_state = HOLD;
         HOLD:       if (bus.cmd_ack) next_state = HDR_ID;
         default:    next_state = HDR_ID;
      endcase
   end

   // Header fields stay frozen through HOLD; only a new ID byte clears overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_id     <= 8'h00;
         cmd_length <= 16'd0;
         overflow   <= 1'b0;
         len_raw    <= 16'd0;
         byte_cnt   <= 16'd0;
         rd_ptr     <= '0;
         cmd_count  <= 8'h00;
      end else begin
         case (state)
            HDR_ID: if (accept) begin
               cmd_id   <= bus.in_data;
               overflow <= 1'b0;
            end
            HDR_LEN_HI: if (accept) len_raw[15:8] <= bus.in_data;
            HDR_LEN_LO: if (accept) begin
               len_raw[7:0] <= bus.in_data;
               byte_cnt     <= 16'd0;
               rd_ptr       <= '0;
               cmd_length   <= (len_full > MAX_LEN) ? MAX_LEN : len_full;
               overflow     <= (len_full > MAX_LEN);
            end
            PAYLOAD: if (accept) begin
               byte_cnt <= byte_cnt + 16'd1;
               if (last_byte) rd_ptr <= '0;
            end
            HOLD: begin
               if (bus.cmd_ack) begin
                  rd_ptr    <= '0;
                  cmd_count <= cmd_count + 8'd1;
               end else if (bus.cmd_read && (rd_ext < cmd_length)) begin
                  rd_ptr <= rd_ptr + PTR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Bytes beyond the buffer depth are still counted but never stored.
   always_ff @(posedge clk) begin
      if (state == PAYLOAD && accept && byte_cnt < MAX_LEN)
         payload_buf[byte_cnt[PTR_W-1:0]] <= bus.in_data;
   end

   always_comb begin
      bus.cmd_data = 8'h00;
      if (state == HOLD && rd_ext < cmd_length) bus.cmd_data = payload_buf[rd_ptr];
   end

endmodule

// File: tb/tb_ep4_cmd_parser.sv
// Directed bench for ep4_cmd_parser: header parsing, clamping, back-pressure, reads, acks and reset.
module tb_ep4_cmd_parser;

   logic       clk;
   logic       reset;
   logic       overflow;
   logic [7:0] cmd_count;
   int         checks;
   int         errors;

   ep4_cmd_parser_if bus ();

   ep4_cmd_parser #(.MAX_COMMAND_LENGTH(8), .PTR_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .overflow  (overflow),
      .cmd_count (cmd_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Called at a negedge; returns at the negedge after the byte was accepted.
   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) check_output("accept_timeout", 32'd0, 32'd1);
      else begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_ack();
      bus.in_valid = 1'b0;
      bus.cmd_ack  = 1'b1;
      @(negedge clk);
      bus.cmd_ack  = 1'b0;
   endtask

   logic [7:0] exp_reads [9];

   initial begin
      checks       = 0;
      errors       = 0;
      reset        = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;
      bus.cmd_read = 1'b0;
      bus.cmd_ack  = 1'b0;
      repeat (2) @(negedge clk);
      check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check_output("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check_output("rst_cmd_count", 32'(cmd_count), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Basic two-byte command, back to back.
      send_byte(8'h31); send_byte(8'h00); send_byte(8'h02); send_byte(8'h05);
      check_output("t1_not_ready_yet", 32'(bus.cmd_ready), 32'd0);
      send_byte(8'h07);
      bus.in_valid = 1'b0;
      check_output("t1_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check_output("t1_in_ready", 32'(bus.in_ready), 32'd0);
      check_output("t1_cmd_id", 32'(bus.cmd_id), 32'h31);
      check_output("t1_cmd_length", 32'(bus.cmd_length), 32'd2);
      check_output("t1_overflow", 32'(overflow), 32'd0);
      bus.cmd_read = 1'b1;
      check_output("t1_data0", 32'(bus.cmd_data), 32'h05);
      @(negedge clk);
      check_output("t1_data1", 32'(bus.cmd_data), 32'h07);
      @(negedge clk);
      check_output("t1_data2", 32'(bus.cmd_data), 32'h00);
      @(negedge clk);
      bus.cmd_read = 1'b0;
      check_output("t1_data_sat", 32'(bus.cmd_data), 32'h00);
      pulse_ack();
      check_output("t1_ack_ready", 32'(bus.cmd_ready), 32'd0);
      check_output("t1_ack_in_ready", 32'(bus.in_ready), 32'd1);
      check_output("t1_count", 32'(cmd_count), 32'd1);

      // Zero-length command goes straight to HOLD.
      send_byte(8'h40); send_byte(8'h00); send_byte(8'h00);
      bus.in_valid = 1'b0;
      check_output("t2_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check_output("t2_cmd_id", 32'(bus.cmd_id), 32'h40);
      check_output("t2_cmd_length", 32'(bus.cmd_length), 32'd0);
      check_output("t2_cmd_data", 32'(bus.cmd_data), 32'h00);
      pulse_ack();
      check_output("t2_count", 32'(cmd_count), 32'd2);
      check_output("t2_in_ready", 32'(bus.in_ready), 32'd1);

      // Length 10 clamps to 8 and flags overflow.
      send_byte(8'h0A); send_byte(8'h00); send_byte(8'h0A);
      for (int i = 1; i <= 9; i++) send_byte(8'(i));
      check_output("t3_not_ready_yet", 32'(bus.cmd_ready), 32'd0);
      send_byte(8'h0A);
      bus.in_valid = 1'b0;
      check_output("t3_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check_output("t3_cmd_length", 32'(bus.cmd_length), 32'd8);
      check_output("t3_overflow", 32'(overflow), 32'd1);
      exp_reads = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00};
      bus.cmd_read = 1'b1;
      for (int i = 0; i < 9; i++) begin
         check_output($sformatf("t3_data%0d", i), 32'(bus.cmd_data), 32'(exp_reads[i]));
         @(negedge clk);
      end
      bus.cmd_read = 1'b0;
      pulse_ack();
      check_output("t3_count", 32'(cmd_count), 32'd3);
      check_output("t3_overflow_held", 32'(overflow), 32'd1);

      // Bytes offered during HOLD are back-pressured and taken after the ack.
      send_byte(8'h21); send_byte(8'h00); send_byte(8'h01); send_byte(8'h99);
      bus.in_data  = 8'h77;
      bus.in_valid = 1'b1;
      repeat (3) @(negedge clk);
      check_output("t4_hold_in_ready", 32'(bus.in_ready), 32'd0);
      check_output("t4_hold_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check_output("t4_hold_cmd_id", 32'(bus.cmd_id), 32'h21);
      check_output("t4_hold_data", 32'(bus.cmd_data), 32'h99);
      bus.cmd_ack = 1'b1;
      @(negedge clk);
      bus.cmd_ack = 1'b0;
      check_output("t4_ack_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check_output("t4_pending_id", 32'(bus.cmd_id), 32'h77);
      check_output("t4_overflow_cleared", 32'(overflow), 32'd0);
      send_byte(8'h00); send_byte(8'h00);
      bus.in_valid = 1'b0;
      check_output("t4_len0_ready", 32'(bus.cmd_ready), 32'd1);
      pulse_ack();
      check_output("t4_count", 32'(cmd_count), 32'd5);

      // Gaps between every byte.
      send_byte(8'h31); idle(2);
      send_byte(8'h00); idle(2);
      send_byte(8'h01); idle(2);
      check_output("t5_not_ready_yet", 32'(bus.cmd_ready), 32'd0);
      send_byte(8'hAA);
      bus.in_valid = 1'b0;
      check_output("t5_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check_output("t5_cmd_id", 32'(bus.cmd_id), 32'h31);
      check_output("t5_cmd_length", 32'(bus.cmd_length), 32'd1);
      check_output("t5_data0", 32'(bus.cmd_data), 32'hAA);
      bus.cmd_read = 1'b1;
      @(negedge clk);
      bus.cmd_read = 1'b0;
      check_output("t5_data1", 32'(bus.cmd_data), 32'h00);
      pulse_ack();
      check_output("t5_count", 32'(cmd_count), 32'd6);

      // Reset in the middle of a payload discards the partial command.
      send_byte(8'h31); send_byte(8'h00); send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
      bus.in_valid = 1'b0;
      reset = 1'b0;
      #1;
      check_output("t6_in_ready", 32'(bus.in_ready), 32'd1);
      check_output("t6_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check_output("t6_cmd_id", 32'(bus.cmd_id), 32'h00);
      check_output("t6_cmd_length", 32'(bus.cmd_length), 32'd0);
      check_output("t6_cmd_data", 32'(bus.cmd_data), 32'h00);
      check_output("t6_overflow", 32'(overflow), 32'd0);
      check_output("t6_count", 32'(cmd_count), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      send_byte(8'h31); send_byte(8'h00); send_byte(8'h01); send_byte(8'h55);
      bus.in_valid = 1'b0;
      check_output("t6_new_ready", 32'(bus.cmd_ready), 32'd1);
      check_output("t6_new_id", 32'(bus.cmd_id), 32'h31);
      check_output("t6_new_length", 32'(bus.cmd_length), 32'd1);
      check_output("t6_new_data", 32'(bus.cmd_data), 32'h55);
      pulse_ack();
      check_output("t6_new_count", 32'(cmd_count), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ep4_cmd_parser.md
# ep4_cmd_parser

Byte-stream command deframer sitting directly upstream of the controller's EP4 command port. Accepts raw bytes drained from the FX2 EP4 endpoint FIFO and parses the 3-byte header (ID, length MSB, length LSB). Buffers up to MAX_COMMAND_LENGTH payload bytes and presents the finished command on the controller's ep4_cmd_id / ep4_cmd_length / ep4_ready / ep4_read / ep4_data port. The controller's ep4_clk is tied to this block's clk at top level.

## Interface
- MAX_COMMAND_LENGTH, 8: payload buffer depth in bytes; must match the controller.
- PTR_W, 4: width of the buffer read pointer; must satisfy 2^PTR_W > MAX_COMMAND_LENGTH.
- clk  in  1  system clock; also drives the controller's ep4_clk.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  8  next byte from the EP4 endpoint FIFO.
- in_valid  in  1  in_data holds a byte.
- in_ready  out  1  block accepts a byte; transfer happens when in_valid && in_ready at a rising clk edge.
- cmd_id  out  8  latched command ID; connects to ep4_cmd_id.
- cmd_length  out  16  payload byte count presented, min(header length, MAX_COMMAND_LENGTH); connects to ep4_cmd_length.
- cmd_ready  out  1  complete command held; connects to ep4_ready.
- cmd_read  in  1  level read strobe; connects to ep4_read.
- cmd_data  out  8  current payload byte; connects to ep4_data.
- cmd_ack  in  1  one-cycle pulse: command consumed. Driven by top-level glue when the controller's EP4 machine reaches DONE.
- overflow  out  1  sticky for the held command: header length exceeded MAX_COMMAND_LENGTH.
- cmd_count  out  8  number of commands completed (acked); wraps 255→0.

## Operation
- FSM states: HDR_ID, HDR_LEN_HI, HDR_LEN_LO, PAYLOAD, HOLD. Reset state is HDR_ID.
- in_ready = (state != HOLD), combinational from the state register.
- HDR_ID: on accept, cmd_id ← in_data, overflow ← 0, go to HDR_LEN_HI.
- HDR_LEN_HI: on accept, len_raw[15:8] ← in_data, go to HDR_LEN_LO.
- HDR_LEN_LO: on accept, len_raw[7:0] ← in_data and byte_cnt ← 0.
  - If the full 16-bit length is 0, go to HOLD.
  - Otherwise go to PAYLOAD.
  - cmd_length ← min(len, MAX_COMMAND_LENGTH).
  - overflow ← (len > MAX_COMMAND_LENGTH).
- PAYLOAD: on each accept, if byte_cnt < MAX_COMMAND_LENGTH then buf[byte_cnt] ← in_data; otherwise the byte is discarded.
  - byte_cnt (16-bit) increments on every accept.
  - When the accepted byte is number len_raw (byte_cnt == len_raw−1), go to HOLD and set rd_ptr ← 0.
- HOLD: cmd_ready = 1.
  - cmd_data = buf[rd_ptr] if rd_ptr < cmd_length, else 8'h00.
  - On cmd_read, rd_ptr increments, saturating at cmd_length. Extra read cycles are harmless.
  - On cmd_ack: go to HDR_ID, cmd_ready ← 0, cmd_count increments, rd_ptr ← 0.
- cmd_ack outside HOLD is ignored. cmd_read outside HOLD is ignored.
- cmd_id, cmd_length and overflow stay stable from HOLD entry until the next header ID byte is accepted.
- Reset values (any state, mid-command included): state HDR_ID, in_ready 1, cmd_id 0, cmd_length 0, cmd_ready 0, cmd_data 0, overflow 0, cmd_count 0, rd_ptr 0, byte_cnt 0. A partially received command is discarded.

## Timing
- Throughput: one byte per clk while in_ready.
- Back-pressure: in_ready drops in the cycle after the last header/payload byte is accepted, i.e. the same edge that enters HOLD.
- cmd_ready rises one cycle after the final byte is accepted.
- Latency to cmd_ready: length-0 command, 3 accept cycles + 1; length N command, 3 + N accept cycles + 1.
- cmd_data is combinational from rd_ptr. The byte at the current rd_ptr is valid in the same cycle cmd_read is high, and the next byte appears after the edge.
- cmd_ack → cmd_ready low and in_ready high one cycle later. The next header byte can be accepted on that cycle.
- Simultaneous cmd_read and cmd_ack: ack wins; rd_ptr ← 0.

## Test plan
- Feed 31 00 02 05 07 with in_valid held high -> cmd_ready rises 1 cycle after byte 07; cmd_id=8'h31, cmd_length=2. With cmd_read high 3 cycles, cmd_data = 05, 07, 00; overflow=0.
- Length-0 command 40 00 00 -> HOLD after 3 accepts; cmd_length=0, cmd_data=00. cmd_ack -> cmd_count=1, in_ready=1 next cycle.
- Length 10, payload 01..0A -> all 13 bytes accepted; cmd_length=8, overflow=1; reads return 01..08.
- In HOLD, drive in_valid with bytes -> in_ready=0 and no state change. After cmd_ack, the pending byte is accepted as the next cmd_id.
- Bursty in_valid (gaps between every byte) on 31 00 01 AA -> same result as the back-to-back case; no byte lost or duplicated.
- Assert reset low after 2 payload bytes of a length-4 command -> all outputs at reset values. A fresh command 31 00 01 55 then parses correctly.
